// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: PmodJSTK SPI slave emulator (mode 0, 40-bit frame) with a
// Wishbone register port for position, buttons, status and flag clearing.
// Optional feature: define JSTK_RESP_IRQ_EN to add irq_o and the BTN[8] enable.
module jstk_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        SCLK,
  input  logic        SS,
  input  logic        MOSI,
`ifdef JSTK_RESP_IRQ_EN
  output logic        MISO,
  output logic        irq_o
`else
  output logic        MISO
`endif
);

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned RX_W       = 8;
  localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(RX_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [3:0] A_POS    = 4'd0;
  localparam logic [3:0] A_BTN    = 4'd1;
  localparam logic [3:0] A_STATUS = 4'd2;
  localparam logic [3:0] A_CLR    = 4'd3;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_OVER = 2'd2} state_e;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync, r_fill;
  logic r_sclk_d, r_ss_d, r_ss_armed;
  logic w_sclk, w_ss, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;

  state_e r_state, w_state_nxt;
  logic w_load, w_rx_shift, w_tx_shift, w_byte_done, w_frame_done, w_busy;

  logic [FRAME_BITS-1:0] r_tx, w_frame;
  logic [RX_W-1:0]       r_rx, r_cmd_pend, r_cmd;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [7:0]            r_fcnt;
  logic                  r_done, w_done_nxt, r_miso;
  logic [9:0]            r_pos_x, r_pos_y;
  logic [2:0]            r_btn;
  logic                  w_irq_en;

  logic        r_ack, w_wb_go, w_wr, w_clr_done;
  logic [3:0]  w_adr;
  logic [31:0] r_dat_o, w_rd_data;
  logic        w_unused;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // SS falls are only honoured once SS has been genuinely seen high after reset
  assign w_ss_fall   = r_ss_armed & r_ss_d & ~w_ss;
  assign w_ss_rise   = ~r_ss_d & w_ss;
  assign w_sclk_rise = w_sclk & ~r_sclk_d & ~w_ss;
  assign w_sclk_fall = ~w_sclk & r_sclk_d & ~w_ss;

  // Pin synchronizers, edge-detect history and post-reset SS arming
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_fill      <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
      r_ss_armed  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
      if (r_fill[SYNC_STAGES-1] && w_ss) r_ss_armed <= 1'b1;
    end
  end

  // Frame state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state: SS rising edge returns to IDLE from anywhere
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_ss_fall) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_sclk_rise && (r_bit_cnt == CNT_LAST)) w_state_nxt = ST_OVER;
      ST_OVER:   w_state_nxt = ST_OVER;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_ss_rise) w_state_nxt = ST_IDLE;
  end

  // Datapath strobes decoded from state and synchronized edges
  always_comb begin
    w_load     = 1'b0;
    w_rx_shift = 1'b0;
    w_tx_shift = 1'b0;
    case (r_state)
      ST_IDLE:   w_load = w_ss_fall;
      ST_ACTIVE: begin
        w_rx_shift = w_sclk_rise;
        w_tx_shift = w_sclk_fall;
      end
      default: ;
    endcase
  end

  assign w_byte_done  = w_rx_shift & (r_bit_cnt == CNT_BYTE);
  assign w_frame_done = w_rx_shift & (r_bit_cnt == CNT_LAST);
  assign w_busy       = (r_state != ST_IDLE);
  assign w_frame      = {r_pos_x[7:0], 6'b0, r_pos_x[9:8], r_pos_y[7:0], 6'b0, r_pos_y[9:8], 5'b0, r_btn};

  // SPI shifters, bit counter and MISO; command only committed by a full frame
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_cmd_pend <= '0;
      r_cmd      <= '0;
      r_bit_cnt  <= '0;
      r_fcnt     <= '0;
      r_miso     <= 1'b0;
    end else if (w_load) begin
      r_tx      <= w_frame;
      r_miso    <= w_frame[FRAME_BITS-1];
      r_rx      <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_rx_shift) begin
        r_rx      <= {r_rx[RX_W-2:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_byte_done) r_cmd_pend <= {r_rx[RX_W-2:0], w_mosi};
      if (w_tx_shift) begin
        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
        r_miso <= r_tx[FRAME_BITS-2];
      end
      if (w_frame_done) begin
        r_fcnt <= r_fcnt + 8'd1;
        r_cmd  <= r_cmd_pend;
      end
      if (w_frame_done || w_ss_rise) r_miso <= 1'b0;
    end
  end

  assign w_wb_go    = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr       = w_wb_go & wb_we_i;
  assign w_adr      = wb_adr_i[5:2];
  assign w_clr_done = w_wr & (w_adr == A_CLR) & wb_sel_i[0] & wb_dat_i[1];

  // DONE: frame completion wins over a same-cycle clear
  always_comb begin
    w_done_nxt = r_done;
    if (w_clr_done)   w_done_nxt = 1'b0;
    if (w_frame_done) w_done_nxt = 1'b1;
  end

  // Host-writable POS/BTN registers with byte enables, plus DONE flag
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_btn   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_wr && (w_adr == A_POS)) begin
        if (wb_sel_i[0]) r_pos_x[7:0] <= wb_dat_i[7:0];
        if (wb_sel_i[1]) r_pos_x[9:8] <= wb_dat_i[9:8];
        if (wb_sel_i[2]) r_pos_y[7:0] <= wb_dat_i[23:16];
        if (wb_sel_i[3]) r_pos_y[9:8] <= wb_dat_i[25:24];
      end
      if (w_wr && (w_adr == A_BTN) && wb_sel_i[0]) r_btn <= wb_dat_i[2:0];
    end
  end

`ifdef JSTK_RESP_IRQ_EN
  logic r_irq_en, r_irq, w_irq_en_nxt;

  // Interrupt enable lives in BTN bit 8
  always_comb begin
    w_irq_en_nxt = r_irq_en;
    if (w_wr && (w_adr == A_BTN) && wb_sel_i[1]) w_irq_en_nxt = wb_dat_i[8];
  end

  // Registered interrupt tracks next-cycle DONE and enable
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_done_nxt & w_irq_en_nxt;
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq_o    = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  // Read data mux; CLR and unmapped addresses read as zero
  always_comb begin
    w_rd_data = '0;
    case (w_adr)
      A_POS:    w_rd_data = {6'b0, r_pos_y, 6'b0, r_pos_x};
      A_BTN:    w_rd_data = {23'b0, w_irq_en, 5'b0, r_btn};
      A_STATUS: w_rd_data = {8'b0, r_cmd, r_fcnt, 6'b0, r_done, w_busy};
      default:  w_rd_data = '0;
    endcase
  end

  // Single-wait-state acknowledge with registered read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack <= w_wb_go;
      if (w_wb_go) r_dat_o <= w_rd_data;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat_o;
  assign wb_err_o = 1'b0;
  assign MISO     = r_miso;
  assign w_unused = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:26], wb_dat_i[15:10]};

endmodule
